// File: rtl/ascii_decimal_tx.sv
// ascii_decimal_tx
// Converts a 6-bit unsigned value to a three-character ASCII stream:
// tens digit, ones digit, terminator. The tens digit is found by repeated
// subtraction of ten. Characters leave one per valid/ready handshake.
module ascii_decimal_tx #(
  parameter logic [7:0] TERM = 8'h0A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic [7:0] char_data,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CONV = 3'd1;
  localparam logic [2:0] ST_TENS = 3'd2;
  localparam logic [2:0] ST_ONES = 3'd3;
  localparam logic [2:0] ST_TERM = 3'd4;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  logic [2:0] state_reg;
  logic [5:0] rem_reg;
  logic [2:0] tens_reg;

  // Handshake flags are pure decodes of the state so in_ready never
  // depends on in_valid.
  always_comb begin
    in_ready = (state_reg == ST_IDLE);
    busy     = (state_reg != ST_IDLE);
  end

  // Conversion and output sequencing; char_data/char_valid only change on
  // an accepted transfer, so they hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      rem_reg    <= 6'd0;
      tens_reg   <= 3'd0;
      char_valid <= 1'b0;
      char_data  <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            rem_reg   <= in_data;
            tens_reg  <= 3'd0;
            state_reg <= ST_CONV;
          end
        end
        ST_CONV: begin
          // Compare before subtracting so rem never wraps.
          if (rem_reg >= 6'd10) begin
            rem_reg  <= rem_reg - 6'd10;
            tens_reg <= tens_reg + 3'd1;
          end else begin
            char_data  <= ASCII_ZERO + {5'd0, tens_reg};
            char_valid <= 1'b1;
            state_reg  <= ST_TENS;
          end
        end
        ST_TENS: begin
          if (char_ready) begin
            char_data <= ASCII_ZERO + {4'd0, rem_reg[3:0]};
            state_reg <= ST_ONES;
          end
        end
        ST_ONES: begin
          if (char_ready) begin
            char_data <= TERM;
            state_reg <= ST_TERM;
          end
        end
        ST_TERM: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            char_data  <= 8'h00;
            state_reg  <= ST_IDLE;
          end
        end
        default: begin
          char_valid <= 1'b0;
          char_data  <= 8'h00;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
